// File: rtl/main_decoder_mc.sv
// Multi-cycle RV32I main decoder with JAL and a CNN custom opcode that hands off to an accelerator.
// Control bundle is registered (one cycle latency); fetch/decode stall while an accelerator op runs.
module main_decoder_mc #(
    parameter int              OP_W      = 7,
    parameter logic [OP_W-1:0] CUSTOM_OP = 7'b0101011,
    parameter int              TIMEOUT   = 1024,
    parameter int              CNT_W     = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [OP_W-1:0] op,
    output logic            stall,
    output logic            ctrl_valid,
    output logic            RegWrite,
    output logic            ALUSrc,
    output logic            MemWrite,
    output logic            Branch,
    output logic            Jump,
    output logic [1:0]      ResultSrc,
    output logic [1:0]      ImmSrc,
    output logic [1:0]      ALUOp,
    output logic            illegal,
    output logic            accel_req,
    input  logic            accel_ack,
    input  logic            accel_done,
    output logic            timeout_err
);

    localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_STORE  = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_R      = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_I      = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(7'b1100011);
    localparam logic [OP_W-1:0] OP_JAL    = OP_W'(7'b1101111);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC_REQ,
        ACC_WAIT,
        ACC_WB
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             set_timeout;

    logic       nxt_valid, nxt_reg_write, nxt_alu_src, nxt_mem_write;
    logic       nxt_branch, nxt_jump, nxt_illegal;
    logic [1:0] nxt_result_src, nxt_imm_src, nxt_alu_op;

    assign stall     = (state != IDLE) || (instr_valid && (op == CUSTOM_OP));
    assign accel_req = (state == ACC_REQ);

    always_comb begin
        next_state     = state;
        set_timeout    = 1'b0;
        nxt_valid      = 1'b0;
        nxt_reg_write  = 1'b0;
        nxt_alu_src    = 1'b0;
        nxt_mem_write  = 1'b0;
        nxt_branch     = 1'b0;
        nxt_jump       = 1'b0;
        nxt_illegal    = 1'b0;
        nxt_result_src = 2'b00;
        nxt_imm_src    = 2'b00;
        nxt_alu_op     = 2'b00;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    if (op == CUSTOM_OP) begin
                        next_state = ACC_REQ;
                    end else begin
                        nxt_valid = 1'b1;
                        case (op)
                            OP_LOAD: begin
                                nxt_reg_write  = 1'b1;
                                nxt_alu_src    = 1'b1;
                                nxt_result_src = 2'b01;
                            end
                            OP_STORE: begin
                                nxt_mem_write = 1'b1;
                                nxt_alu_src   = 1'b1;
                                nxt_imm_src   = 2'b01;
                            end
                            OP_R: begin
                                nxt_reg_write = 1'b1;
                                nxt_alu_op    = 2'b10;
                            end
                            OP_I: begin
                                nxt_reg_write = 1'b1;
                                nxt_alu_src   = 1'b1;
                                nxt_alu_op    = 2'b10;
                            end
                            OP_BRANCH: begin
                                nxt_branch  = 1'b1;
                                nxt_imm_src = 2'b10;
                                nxt_alu_op  = 2'b01;
                            end
                            OP_JAL: begin
                                nxt_jump       = 1'b1;
                                nxt_reg_write  = 1'b1;
                                nxt_result_src = 2'b10;
                                nxt_imm_src    = 2'b11;
                            end
                            default: nxt_illegal = 1'b1;
                        endcase
                    end
                end
            end
            ACC_REQ: begin
                // A done arriving with the ack wins over a timeout in the same cycle
                if (accel_ack && accel_done) begin
                    next_state = ACC_WB;
                end else if (cnt == CNT_LAST) begin
                    set_timeout = 1'b1;
                    next_state  = IDLE;
                end else if (accel_ack) begin
                    next_state = ACC_WAIT;
                end
            end
            ACC_WAIT: begin
                if (accel_done) begin
                    next_state = ACC_WB;
                end else if (cnt == CNT_LAST) begin
                    set_timeout = 1'b1;
                    next_state  = IDLE;
                end
            end
            ACC_WB: begin
                nxt_valid      = 1'b1;
                nxt_reg_write  = 1'b1;
                nxt_result_src = 2'b11;
                nxt_alu_op     = 2'b11;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            timeout_err <= 1'b0;
            ctrl_valid  <= 1'b0;
            RegWrite    <= 1'b0;
            ALUSrc      <= 1'b0;
            MemWrite    <= 1'b0;
            Branch      <= 1'b0;
            Jump        <= 1'b0;
            ResultSrc   <= 2'b00;
            ImmSrc      <= 2'b00;
            ALUOp       <= 2'b00;
            illegal     <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                cnt <= '0;
            end else if (state == ACC_REQ || state == ACC_WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (set_timeout) begin
                timeout_err <= 1'b1;
            end
            ctrl_valid <= nxt_valid;
            RegWrite   <= nxt_reg_write;
            ALUSrc     <= nxt_alu_src;
            MemWrite   <= nxt_mem_write;
            Branch     <= nxt_branch;
            Jump       <= nxt_jump;
            ResultSrc  <= nxt_result_src;
            ImmSrc     <= nxt_imm_src;
            ALUOp      <= nxt_alu_op;
            illegal    <= nxt_illegal;
        end
    end

endmodule

// File: tb/tb_main_decoder_mc.sv
// Directed testbench for main_decoder_mc: decode table, accelerator handshake,
// timeout abort, illegal opcodes and reset mid-op.
module tb_main_decoder_mc;

    localparam logic [6:0] CUSTOM = 7'b0101011;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic [6:0] op;
    logic       stall, ctrl_valid, RegWrite, ALUSrc, MemWrite, Branch, Jump, illegal;
    logic [1:0] ResultSrc, ImmSrc, ALUOp;
    logic       accel_req, accel_ack, accel_done, timeout_err;
    logic [10:0] bundle;

    int errors = 0;
    int checks = 0;

    main_decoder_mc #(.OP_W(7), .CUSTOM_OP(CUSTOM), .TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .op(op), .stall(stall),
        .ctrl_valid(ctrl_valid), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
        .Branch(Branch), .Jump(Jump), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUOp(ALUOp),
        .illegal(illegal), .accel_req(accel_req), .accel_ack(accel_ack),
        .accel_done(accel_done), .timeout_err(timeout_err)
    );

    // {RegWrite, ALUSrc, MemWrite, Branch, Jump, ResultSrc, ImmSrc, ALUOp}
    assign bundle = {RegWrite, ALUSrc, MemWrite, Branch, Jump, ResultSrc, ImmSrc, ALUOp};

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; op = '0; accel_ack = 1'b0; accel_done = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        checks++;
        if ({stall, ctrl_valid, bundle, illegal, accel_req, timeout_err} !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got stall=%b cv=%b bundle=%b ill=%b req=%b terr=%b, want all 0",
                     stall, ctrl_valid, bundle, illegal, accel_req, timeout_err);
        end
        // done while idle must be ignored
        accel_done = 1'b1;
        cyc();
        accel_done = 1'b0;
        checks++;
        if (ctrl_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_done_ignored: got cv=%b stall=%b, want 0 0", ctrl_valid, stall);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  ops [6];
        logic [10:0] exp [6];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        exp = '{11'b11000_01_00_00, 11'b01100_00_01_00, 11'b10000_00_00_10,
                11'b11000_00_00_10, 11'b00010_00_10_01, 11'b10001_10_11_00};
        for (int i = 0; i < 6; i++) begin
            instr_valid = 1'b1;
            op = ops[i];
            #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_stall[%0d]: got %b, want 0", i, stall);
            end
            cyc();
            checks++;
            if (ctrl_valid !== 1'b1 || illegal !== 1'b0 || bundle !== exp[i]) begin
                errors++;
                $display("[TB] FAIL b2b_decode[%0d]: got cv=%b ill=%b bundle=%b, want cv=1 ill=0 bundle=%b",
                         i, ctrl_valid, illegal, bundle, exp[i]);
            end
        end
        instr_valid = 1'b0;
        cyc();
        checks++;
        if (ctrl_valid !== 1'b0 || bundle !== 11'h0) begin
            errors++;
            $display("[TB] FAIL idle_bubble: got cv=%b bundle=%b, want 0 and 0", ctrl_valid, bundle);
        end
    endtask

    // Runs a custom op for n cycles; ack/done are pulsed in the given cycles (-1 = never).
    task automatic run_custom(input int n, input int ack_c, input int done_c,
                              output int stall_n, output int req_n, output int cv_n,
                              output int cv_c, output logic [10:0] cv_bundle,
                              output int terr_c);
        stall_n = 0; req_n = 0; cv_n = 0; cv_c = -1; cv_bundle = '0; terr_c = -1;
        op = CUSTOM;
        for (int c = 0; c < n; c++) begin
            instr_valid = (c == 0);
            accel_ack   = (c == ack_c);
            accel_done  = (c == done_c);
            #1;
            if (stall) stall_n++;
            if (accel_req) req_n++;
            if (ctrl_valid || RegWrite) begin
                cv_n++;
                cv_c = c;
                cv_bundle = bundle;
            end
            if (timeout_err && terr_c < 0) terr_c = c;
            cyc();
        end
        instr_valid = 1'b0; accel_ack = 1'b0; accel_done = 1'b0;
    endtask

    task automatic test_accel_op();
        int s, r, v, vc, tc;
        logic [10:0] b;
        run_custom(14, 3, 7, s, r, v, vc, b, tc);
        checks++;
        if (s !== 9) begin
            errors++; $display("[TB] FAIL acc_stall_len: got %0d, want 9", s);
        end
        checks++;
        if (r !== 3) begin
            errors++; $display("[TB] FAIL acc_req_len: got %0d, want 3", r);
        end
        checks++;
        if (v !== 1 || vc !== 9 || b !== 11'b10000_11_00_11) begin
            errors++;
            $display("[TB] FAIL acc_writeback: got count=%0d cycle=%0d bundle=%b, want 1 9 10000110011", v, vc, b);
        end
    endtask

    task automatic test_accel_fast();
        int s, r, v, vc, tc;
        logic [10:0] b;
        run_custom(8, 1, 1, s, r, v, vc, b, tc);
        checks++;
        if (s !== 3 || r !== 1) begin
            errors++; $display("[TB] FAIL fast_stall_req: got stall=%0d req=%0d, want 3 1", s, r);
        end
        checks++;
        if (v !== 1 || vc !== 3 || b !== 11'b10000_11_00_11) begin
            errors++;
            $display("[TB] FAIL fast_writeback: got count=%0d cycle=%0d bundle=%b, want 1 3 10000110011", v, vc, b);
        end
    endtask

    task automatic test_timeout();
        int s, r, v, vc, tc;
        logic [10:0] b;
        run_custom(14, -1, -1, s, r, v, vc, b, tc);
        checks++;
        if (r !== 8 || s !== 9) begin
            errors++; $display("[TB] FAIL timeout_req_len: got req=%0d stall=%0d, want 8 9", r, s);
        end
        checks++;
        if (tc !== 9 || v !== 0) begin
            errors++; $display("[TB] FAIL timeout_flag: got first=%0d wb=%0d, want 9 0", tc, v);
        end
        instr_valid = 1'b1;
        op = 7'b0110011;
        cyc();
        instr_valid = 1'b0;
        checks++;
        if (ctrl_valid !== 1'b1 || bundle !== 11'b10000_00_00_10 || timeout_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_timeout_r: got cv=%b bundle=%b terr=%b, want 1 10000000010 1",
                     ctrl_valid, bundle, timeout_err);
        end
    endtask

    task automatic test_illegal_and_reset();
        instr_valid = 1'b1;
        op = 7'b1111111;
        cyc();
        instr_valid = 1'b0;
        checks++;
        if (illegal !== 1'b1 || ctrl_valid !== 1'b1 || bundle !== 11'h0) begin
            errors++;
            $display("[TB] FAIL illegal_pulse: got ill=%b cv=%b bundle=%b, want 1 1 0", illegal, ctrl_valid, bundle);
        end
        cyc();
        checks++;
        if (illegal !== 1'b0 || ctrl_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL illegal_one_cycle: got ill=%b cv=%b, want 0 0", illegal, ctrl_valid);
        end
        instr_valid = 1'b1;
        op = CUSTOM;
        cyc();
        instr_valid = 1'b0;
        accel_ack = 1'b1;
        cyc();
        accel_ack = 1'b0;
        cyc();
        checks++;
        if (stall !== 1'b1 || accel_req !== 1'b0) begin
            errors++; $display("[TB] FAIL in_wait: got stall=%b req=%b, want 1 0", stall, accel_req);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || accel_req !== 1'b0 || timeout_err !== 1'b0 || ctrl_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_op: got stall=%b req=%b terr=%b cv=%b, want 0 0 0 0",
                     stall, accel_req, timeout_err, ctrl_valid);
        end
        accel_done = 1'b1;
        cyc();
        accel_done = 1'b0;
        checks++;
        if (ctrl_valid !== 1'b0 || RegWrite !== 1'b0) begin
            errors++; $display("[TB] FAIL no_wb_after_reset: got cv=%b rw=%b, want 0 0", ctrl_valid, RegWrite);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_accel_op();
        test_accel_fast();
        test_timeout();
        test_illegal_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
